mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit directly downstream of the register file.
- Consumes the two register-file read ports (DA = rs operand, DB = rt operand) and produces the HI/LO result pair, as in a MIPS-style datapath.
- Multi-cycle with a Start/Busy/Done handshake, so the pipeline or controller can stall while it runs.
- Supports unsigned/signed multiply (shift-add) and unsigned/signed divide (restoring).

Parameters:
WIDTH, 32, operand width; Hi and Lo are each WIDTH bits; iteration count = WIDTH

Ports:
Clk      in   1       clock; all state updates on the rising edge
Reset    in   1       reset; synchronous, active-low
Start    in   1       request operation; sampled only in IDLE
Op       in   2       00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
DA       in   WIDTH   operand A (multiplicand / dividend), from register file read port A
DB       in   WIDTH   operand B (multiplier / divisor), from register file read port B
Busy     out  1       high while an operation is in progress
Done     out  1       one-cycle pulse when Hi/Lo take the new result
Hi       out  WIDTH   MULT: upper product; DIV: remainder
Lo       out  WIDTH   MULT: lower product; DIV: quotient
DivZero  out  1       set at completion of a divide whose divisor was 0; cleared at completion of any other op

Behaviour:
- Reset (Reset=0 at a rising edge):
  - state goes to IDLE.
  - Busy, Done, DivZero, Hi and Lo all go to 0.
  - Internal counter and accumulators are cleared.
  - Reset overrides every other input, including during CALC or FIX: the in-flight operation is aborted and never completes.
- State machine has three states:
  - IDLE:
    - On an edge with Start=1, capture DA, DB and Op.
    - For signed ops, take operand magnitudes and record the result signs.
    - Clear the counter and go to CALC. Busy=1 from the next cycle.
    - With Start=0, remain in IDLE.
  - CALC: one iteration per edge for exactly WIDTH edges.
    - Multiply: add the multiplicand to the upper accumulator if multiplier bit0=1, then shift right by one.
    - Divide: shift the remainder/quotient pair left, trial-subtract the divisor, and keep the difference if it is non-negative (quotient bit = 1).
    - After WIDTH iterations, go to FIX.
  - FIX (one edge):
    - Apply sign correction and write Hi/Lo.
    - Set Done=1 and Busy=0, update DivZero, return to IDLE.
- Latency: with the Start edge as edge 0, the iterations occur on edges 1..WIDTH and FIX on edge WIDTH+1. For WIDTH=32, Done is high during the 33rd cycle after the Start edge.
- Done is high for exactly one cycle. Hi/Lo change only at the FIX edge and hold until the next completion.
- Start handling:
  - Start while Busy=1 is ignored (no restart, no queuing).
  - Start during the Done-high cycle is accepted, because the state is already IDLE, so back-to-back operations are possible.
- Operand isolation: after capture, changes on DA, DB and Op have no effect on the running operation.
- Signed multiply: the 2·WIDTH-bit product is negated if exactly one operand is negative.
- Signed divide:
  - Quotient truncates toward zero and is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Overflow case -2^(WIDTH-1) / -1 gives Lo=0x80000000, Hi=0 (no trap).
- Divide by zero (DB=0, Op=10 or 11):
  - Full latency is still taken.
  - Result is Hi = captured DA (raw, unmodified), Lo = all ones, DivZero=1.
- All arithmetic is modulo 2^(2·WIDTH). The upper accumulator is WIDTH+1 bits wide, so the carry out of the multiply add is preserved.

Test Plan:
- MULTU DA=0xFFFFFFFF, DB=0xFFFFFFFF, Start pulsed 1 cycle -> Busy=1 next cycle; Done pulse 33 cycles after the Start edge; Hi=0xFFFFFFFE, Lo=0x00000001; DivZero=0.
- MULT DA=0xFFFFFFFD (-3), DB=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1 (-15); MULT 0x80000000 x 0x80000000 -> Hi=0x40000000, Lo=0.
- DIVU 100/7 -> Lo=14, Hi=2. DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 7/-2 -> Lo=0xFFFFFFFD, Hi=1. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU DA=0x1234, DB=0 -> Done at cycle 33; Hi=0x1234, Lo=0xFFFFFFFF, DivZero=1. A following MULTU 2x3 -> Lo=6, Hi=0, DivZero=0.
- Start MULTU 6x7:
  - Change DA/DB and re-pulse Start at cycle 5 -> ignored; result Lo=42, exactly one Done pulse.
  - Pulse Start with DIVU 9/2 during the Done cycle -> accepted; Lo=4, Hi=1 after 33 more cycles.
- Start MULTU 6x7, drive Reset=0 at cycle 10 for one edge -> Busy=0, Done=0, Hi=Lo=0 immediately. No Done pulse appears afterwards, and the next Start behaves normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit producing a HI/LO pair from register-file operands.
// Shift-add multiply and restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] DA,
  input  logic [WIDTH-1:0] DB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH:0]       acc_hi_r;
  logic [WIDTH-1:0]     acc_lo_r;
  logic [WIDTH-1:0]     opb_r;
  logic [WIDTH-1:0]     raw_a_r;
  logic                 is_div_r;
  logic                 neg_q_r;
  logic                 neg_r_r;
  logic                 div_zero_r;

  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH+1:0]     div_diff_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quot_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Magnitude of a value, only when it is to be treated as signed.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) state_next_s = CALC;
        else       state_next_s = IDLE;
      end
      CALC: begin
        if (cnt_r == CNT_LAST) state_next_s = FIX;
        else                   state_next_s = CALC;
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Single iteration step for both algorithms and the final sign correction.
  always_comb begin
    mul_sum_s   = acc_hi_r + (acc_lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_hi_r[WIDTH-1:0], acc_lo_r[WIDTH-1]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, opb_r};
    prod_s      = {acc_hi_r[WIDTH-1:0], acc_lo_r};
    prod_fix_s  = neg_q_r ? (~prod_s + (2*WIDTH)'(1)) : prod_s;
    quot_fix_s  = neg_q_r ? neg_w(acc_lo_r) : acc_lo_r;
    rem_fix_s   = neg_r_r ? neg_w(acc_hi_r[WIDTH-1:0]) : acc_hi_r[WIDTH-1:0];
  end

  // Datapath: operand capture, iteration, and result/handshake registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_r      <= {CW{1'b0}};
      acc_hi_r   <= {(WIDTH+1){1'b0}};
      acc_lo_r   <= {WIDTH{1'b0}};
      opb_r      <= {WIDTH{1'b0}};
      raw_a_r    <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Hi         <= {WIDTH{1'b0}};
      Lo         <= {WIDTH{1'b0}};
      DivZero    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            // Multiply: opb = multiplicand, acc_lo = multiplier. Divide: opb = divisor, acc_lo = dividend.
            opb_r      <= Op[1] ? mag(DB, Op[0]) : mag(DA, Op[0]);
            acc_lo_r   <= Op[1] ? mag(DA, Op[0]) : mag(DB, Op[0]);
            acc_hi_r   <= {(WIDTH+1){1'b0}};
            raw_a_r    <= DA;
            is_div_r   <= Op[1];
            neg_q_r    <= Op[0] & (DA[WIDTH-1] ^ DB[WIDTH-1]);
            neg_r_r    <= Op[0] & DA[WIDTH-1];
            div_zero_r <= Op[1] & (DB == {WIDTH{1'b0}});
            cnt_r      <= {CW{1'b0}};
            Busy       <= 1'b1;
          end
        end
        CALC: begin
          cnt_r <= cnt_r + CW'(1);
          if (is_div_r) begin
            if (!div_diff_s[WIDTH+1]) begin
              acc_hi_r <= div_diff_s[WIDTH:0];
              acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_r <= div_shift_s;
              acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi_r <= {1'b0, mul_sum_s[WIDTH:1]};
            acc_lo_r <= {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div_r && div_zero_r) begin
            Hi <= raw_a_r;
            Lo <= {WIDTH{1'b1}};
          end else if (is_div_r) begin
            Hi <= rem_fix_s;
            Lo <= quot_fix_s;
          end else begin
            Hi <= prod_fix_s[2*WIDTH-1:WIDTH];
            Lo <= prod_fix_s[WIDTH-1:0];
          end
          DivZero <= is_div_r & div_zero_r;
          Done    <= 1'b1;
          Busy    <= 1'b0;
        end
        default: begin
          Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
